// File: rtl/stream_arb_4_1.sv
// Four-input round-robin stream arbiter feeding a one-entry registered output stage.
// out_src carries the granted channel index so downstream muxing can reuse it as a select.
module stream_arb_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [1:0]   out_src_q, out_src_d;
    logic [1:0]   ptr_q, ptr_d;

    logic         load_en;
    logic         grant_valid;
    logic [1:0]   grant;
    logic [1:0]   idx;
    logic [W-1:0] sel_data;

    // The register can take a word when empty or when its word leaves this same cycle.
    assign load_en = !out_valid_q || out_ready;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 2'd0;
        idx         = 2'd0;
        // Offset 4 wraps back to ptr itself, so the last-granted channel is searched last.
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!grant_valid && in_valid[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

    always_comb begin
        in_ready = 4'b0000;
        if (load_en && grant_valid) begin
            in_ready = 4'b0001 << grant;
        end
    end

    always_comb begin
        sel_data = in_data0;
        case (grant)
            2'd0:    sel_data = in_data0;
            2'd1:    sel_data = in_data1;
            2'd2:    sel_data = in_data2;
            default: sel_data = in_data3;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (grant_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_src_d   = grant;
                ptr_d       = grant;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            ptr_q       <= 2'd3;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_arb_4_1.sv
// Directed bench for stream_arb_4_1: expected words are queued by the stimulus
// and a negedge monitor pops and compares each word the consumer accepts.
module tb_stream_arb_4_1;

    localparam int W = 8;

    typedef struct packed {
        logic [1:0]   src;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   in_valid = 4'b0000;
    logic [3:0]   in_ready;
    logic [W-1:0] in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    stream_arb_4_1 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] src, input logic [W-1:0] data);
        exp_t e;
        e.src  = src;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word is consumed at the next edge whenever out_valid && out_ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_word: unexpected word src=%0d data=%0h at %0t", out_src, out_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_src", 32'(out_src), 32'(e.src));
                check("out_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        step();

        // Round robin, all four valid
        in_data0 = 8'h0A; in_data1 = 8'h0B; in_data2 = 8'h0C; in_data3 = 8'h0D;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("rr_first_ready", 32'(in_ready), 32'h1);
        for (int r = 0; r < 2; r++) begin
            push(2'd0, 8'h0A); push(2'd1, 8'h0B); push(2'd2, 8'h0C); push(2'd3, 8'h0D);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 7) in_valid = 4'b0000;
            check("rr_out_valid", 32'(out_valid), 32'd1);
        end
        step();
        check("rr_drained", 32'(out_valid), 32'd0);

        // Backpressure
        in_valid = 4'b0010; in_data1 = 8'h21; out_ready = 1'b0;
        push(2'd1, 8'h21);
        step();
        in_valid = 4'b0110; in_data1 = 8'h31; in_data2 = 8'h32;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'h21);
            check("bp_out_src", 32'(out_src), 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h4);
        push(2'd2, 8'h32);
        step();
        in_valid = 4'b0000;
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Sparse traffic on channel 2
        for (int j = 0; j < 4; j++) begin
            in_valid = 4'b0100;
            in_data2 = W'(8'h40 + j);
            push(2'd2, W'(8'h40 + j));
            step();
            in_valid = 4'b0000;
            check("sp_valid_hi", 32'(out_valid), 32'd1);
            check("sp_src", 32'(out_src), 32'd2);
            step();
            check("sp_valid_lo", 32'(out_valid), 32'd0);
        end

        // Pointer skip from ptr=1 with channels 0 and 3 requesting
        in_valid = 4'b0010; in_data1 = 8'h51;
        push(2'd1, 8'h51);
        step();
        in_valid = 4'b1001; in_data0 = 8'h60; in_data3 = 8'h63;
        #1;
        check("skip_grant3", 32'(in_ready), 32'h8);
        push(2'd3, 8'h63);
        step();
        check("skip_src3", 32'(out_src), 32'd3);
        in_valid = 4'b0001;
        #1;
        check("skip_grant0", 32'(in_ready), 32'h1);
        push(2'd0, 8'h60);
        step();
        in_valid = 4'b0000;
        check("skip_src0", 32'(out_src), 32'd0);
        step();

        // Simultaneous drain and load
        in_valid = 4'b0100; in_data2 = 8'h72;
        push(2'd2, 8'h72);
        step();
        in_valid = 4'b0010; in_data1 = 8'h71;
        #1;
        check("dl_in_ready", 32'(in_ready), 32'h2);
        push(2'd1, 8'h71);
        step();
        in_valid = 4'b0000;
        out_ready = 1'b0;
        check("dl_out_valid", 32'(out_valid), 32'd1);
        check("dl_out_data", 32'(out_data), 32'h71);
        check("dl_out_src", 32'(out_src), 32'd1);

        // Asynchronous reset while holding a word
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_src", 32'(out_src), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        in_valid = 4'b1111;
        in_data0 = 8'h80; in_data1 = 8'h81; in_data2 = 8'h82; in_data3 = 8'h83;
        out_ready = 1'b1;
        #1;
        check("arst_first_ready", 32'(in_ready), 32'h1);
        push(2'd0, 8'h80);
        step();
        in_valid = 4'b0000;
        check("arst_first_src", 32'(out_src), 32'd0);
        step();
        step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
